// File: rtl/usb_token_decoder_if.sv
// axi_stream_iface -- byte stream carrying received USB packets, PID byte first.
//
// Handshake: a beat transfers on a rising clk edge where tvalid && tready are
// both 1. The master holds tdata/tlast stable while tvalid=1 and tready=0.
// tlast marks the final byte of a packet.
//
// Signals:
//   tvalid  master -> slave  beat present
//   tready  slave  -> master slave can accept the beat
//   tdata   master -> slave  packet byte
//   tlast   master -> slave  last byte of packet
interface axi_stream_iface;
  logic       tvalid;
  logic       tready;
  logic [7:0] tdata;
  logic       tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/usb_token_decoder.sv
// usb_token_decoder -- decodes received USB packets into token (OUT/IN/SETUP),
// SOF and "other packet" events, with CRC5/length/PID/endpoint error pulses.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   rx               slave byte stream (tready tied high)
//   dev_addr         assigned device address, used for token filtering
//   tok_valid/type/addr/ep   accepted token pulse and its fields
//   sof_valid/sof_frame      start-of-frame pulse and frame number
//   other_valid/other_pid    non-token packet start pulse and PID[3:0]
//   err_pid/crc/len/ep       one-cycle error pulses
//   err_count        saturating count of cycles with an error pulse
//   dbg_state        current decoder state
module usb_token_decoder #(
  parameter int NUM_EP      = 16,
  parameter int CHECK_CRC   = 1,
  parameter int ADDR_FILTER = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  axi_stream_iface.slave rx,
  input  logic [6:0]  dev_addr,
  output logic        tok_valid,
  output logic [1:0]  tok_type,
  output logic [6:0]  tok_addr,
  output logic [3:0]  tok_ep,
  output logic        sof_valid,
  output logic [10:0] sof_frame,
  output logic        other_valid,
  output logic [3:0]  other_pid,
  output logic        err_pid,
  output logic        err_crc,
  output logic        err_len,
  output logic        err_ep,
  output logic [15:0] err_count,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {S_IDLE, S_TOK1, S_TOK2, S_CHECK, S_SKIP} state_e;
  typedef enum logic [2:0] {EV_NONE, EV_PID, EV_LEN, EV_OTHER,
                            EV_CRC, EV_SOF, EV_EP, EV_TOK} ev_e;

  localparam logic [4:0] EP_LIM = 5'(NUM_EP);

  // CRC5 over 11 bits LSB-first, poly x^5+x^2+1, init all ones; returns the
  // raw remainder (the packet carries its inverse).
  function automatic logic [4:0] crc5_rem(input logic [10:0] d);
    logic [4:0] c;
    logic       fb;
    c = 5'h1f;
    for (int i = 0; i < 11; i++) begin
      fb = d[i] ^ c[4];
      c  = {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
    end
    return c;
  endfunction

  state_e      state_q, state_d;
  logic [1:0]  pid_hi_q, pid_hi_d;
  logic [7:0]  byte1_q, byte1_d, byte2_q, byte2_d;
  ev_e         pend_ev_q, pend_ev_d;
  logic [3:0]  pend_pid_q, pend_pid_d;
  logic        tok_valid_q, tok_valid_d, sof_valid_q, sof_valid_d;
  logic        other_valid_q, other_valid_d;
  logic [1:0]  tok_type_q, tok_type_d;
  logic [6:0]  tok_addr_q, tok_addr_d;
  logic [3:0]  tok_ep_q, tok_ep_d, other_pid_q, other_pid_d;
  logic [10:0] sof_frame_q, sof_frame_d;
  logic        err_pid_q, err_pid_d, err_crc_q, err_crc_d;
  logic        err_len_q, err_len_d, err_ep_q, err_ep_d;
  logic [15:0] err_count_q, err_count_d;

  ev_e        beat_ev, check_ev, out_ev;
  logic [3:0] out_pid, ck_ep;
  logic [6:0] ck_addr;
  logic       pid_ok, crc_ok, any_err;

  assign rx.tready = 1'b1;
  assign ck_ep     = {byte2_q[2:0], byte1_q[7]};
  assign ck_addr   = byte1_q[6:0];
  assign pid_ok    = (rx.tdata[7:4] == ~rx.tdata[3:0]);

  // Packet framing: CHECK handles an arriving beat exactly like IDLE so a
  // packet that follows a token back-to-back loses no byte.
  always_comb begin
    state_d  = state_q;
    pid_hi_d = pid_hi_q;
    byte1_d  = byte1_q;
    byte2_d  = byte2_q;
    beat_ev  = EV_NONE;
    if (state_q == S_CHECK) state_d = S_IDLE;
    if (rx.tvalid) begin
      unique case (state_q)
        S_IDLE, S_CHECK: begin
          if (!pid_ok) begin
            beat_ev = EV_PID;
            state_d = rx.tlast ? S_IDLE : S_SKIP;
          end else if (rx.tdata[1:0] == 2'b01) begin
            if (rx.tlast) begin
              beat_ev = EV_LEN;
              state_d = S_IDLE;
            end else begin
              pid_hi_d = rx.tdata[3:2];
              state_d  = S_TOK1;
            end
          end else begin
            beat_ev = EV_OTHER;
            state_d = rx.tlast ? S_IDLE : S_SKIP;
          end
        end
        S_TOK1: begin
          byte1_d = rx.tdata;
          if (rx.tlast) begin
            beat_ev = EV_LEN;
            state_d = S_IDLE;
          end else begin
            state_d = S_TOK2;
          end
        end
        S_TOK2: begin
          byte2_d = rx.tdata;
          if (rx.tlast) begin
            state_d = S_CHECK;
          end else begin
            beat_ev = EV_LEN;
            state_d = S_SKIP;
          end
        end
        S_SKIP:  if (rx.tlast) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Verdict on a complete 3-byte token, meaningful only in CHECK.
  always_comb begin
    crc_ok   = (CHECK_CRC == 0) || (byte2_q[7:3] == ~crc5_rem({ck_ep, ck_addr}));
    check_ev = EV_NONE;
    if (!crc_ok)                                   check_ev = EV_CRC;
    else if (pid_hi_q == 2'b01)                    check_ev = EV_SOF;
    else if (ADDR_FILTER != 0 && ck_addr != dev_addr) check_ev = EV_NONE;
    else if ({1'b0, ck_ep} >= EP_LIM)              check_ev = EV_EP;
    else                                           check_ev = EV_TOK;
  end

  // Output slot arbitration. The CHECK verdict owns its cycle; a beat event
  // decoded in the same cycle slips into a one-entry pending slot and is
  // emitted next cycle. While the slot is busy each new beat event takes its
  // place, so order is preserved and at most one pulse fires per cycle.
  always_comb begin
    out_ev     = EV_NONE;
    out_pid    = rx.tdata[3:0];
    pend_ev_d  = EV_NONE;
    pend_pid_d = pend_pid_q;
    if (state_q == S_CHECK) begin
      out_ev     = check_ev;
      pend_ev_d  = beat_ev;
      pend_pid_d = rx.tdata[3:0];
    end else if (pend_ev_q != EV_NONE) begin
      out_ev     = pend_ev_q;
      out_pid    = pend_pid_q;
      pend_ev_d  = beat_ev;
      pend_pid_d = rx.tdata[3:0];
    end else begin
      out_ev = beat_ev;
    end

    tok_valid_d   = (out_ev == EV_TOK);
    sof_valid_d   = (out_ev == EV_SOF);
    other_valid_d = (out_ev == EV_OTHER);
    err_pid_d     = (out_ev == EV_PID);
    err_len_d     = (out_ev == EV_LEN);
    err_crc_d     = (out_ev == EV_CRC);
    err_ep_d      = (out_ev == EV_EP);
    any_err       = err_pid_d | err_len_d | err_crc_d | err_ep_d;

    tok_type_d  = tok_type_q;
    tok_addr_d  = tok_addr_q;
    tok_ep_d    = tok_ep_q;
    sof_frame_d = sof_frame_q;
    other_pid_d = other_pid_q;
    if (tok_valid_d) begin
      tok_type_d = pid_hi_q;
      tok_addr_d = ck_addr;
      tok_ep_d   = ck_ep;
    end
    if (sof_valid_d)   sof_frame_d = {ck_ep, ck_addr};
    if (other_valid_d) other_pid_d = out_pid;

    err_count_d = err_count_q;
    if (any_err && err_count_q != 16'hffff) err_count_d = err_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pid_hi_q      <= '0;
      byte1_q       <= '0;
      byte2_q       <= '0;
      pend_ev_q     <= EV_NONE;
      pend_pid_q    <= '0;
      tok_valid_q   <= 1'b0;
      sof_valid_q   <= 1'b0;
      other_valid_q <= 1'b0;
      tok_type_q    <= '0;
      tok_addr_q    <= '0;
      tok_ep_q      <= '0;
      sof_frame_q   <= '0;
      other_pid_q   <= '0;
      err_pid_q     <= 1'b0;
      err_crc_q     <= 1'b0;
      err_len_q     <= 1'b0;
      err_ep_q      <= 1'b0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      pid_hi_q      <= pid_hi_d;
      byte1_q       <= byte1_d;
      byte2_q       <= byte2_d;
      pend_ev_q     <= pend_ev_d;
      pend_pid_q    <= pend_pid_d;
      tok_valid_q   <= tok_valid_d;
      sof_valid_q   <= sof_valid_d;
      other_valid_q <= other_valid_d;
      tok_type_q    <= tok_type_d;
      tok_addr_q    <= tok_addr_d;
      tok_ep_q      <= tok_ep_d;
      sof_frame_q   <= sof_frame_d;
      other_pid_q   <= other_pid_d;
      err_pid_q     <= err_pid_d;
      err_crc_q     <= err_crc_d;
      err_len_q     <= err_len_d;
      err_ep_q      <= err_ep_d;
      err_count_q   <= err_count_d;
    end
  end

  assign tok_valid   = tok_valid_q;
  assign tok_type    = tok_type_q;
  assign tok_addr    = tok_addr_q;
  assign tok_ep      = tok_ep_q;
  assign sof_valid   = sof_valid_q;
  assign sof_frame   = sof_frame_q;
  assign other_valid = other_valid_q;
  assign other_pid   = other_pid_q;
  assign err_pid     = err_pid_q;
  assign err_crc     = err_crc_q;
  assign err_len     = err_len_q;
  assign err_ep      = err_ep_q;
  assign err_count   = err_count_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_usb_token_decoder.sv
// Bench for usb_token_decoder: four instances with different parameter sets
// share one byte stream; a packet-level model predicts each instance's pulse.
module tb_usb_token_decoder;
  localparam int NI = 4;
  localparam int NE_P [NI] = '{16, 4, 16, 16};
  localparam int CC_P [NI] = '{1, 1, 1, 0};
  localparam int AF_P [NI] = '{1, 1, 0, 1};
  localparam int W = 64;
  localparam logic [3:0] K_NONE = 4'd0, K_TOK = 4'd1, K_SOF = 4'd2, K_OTH = 4'd3,
                         K_PID = 4'd4, K_LEN = 4'd5, K_CRC = 4'd6, K_EP = 4'd7;
  localparam logic [7:0] PID_TAB [8] = '{8'hE1, 8'h69, 8'h2D, 8'hA5,
                                         8'hC3, 8'h4B, 8'hD2, 8'h5A};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tvalid = 1'b0, tlast = 1'b0;
  logic [7:0] tdata = 8'h00;
  logic [6:0] dev_addr = 7'h15;

  logic        tready_w [NI];
  logic        tok_valid [NI], sof_valid [NI], other_valid [NI];
  logic [1:0]  tok_type [NI];
  logic [6:0]  tok_addr [NI];
  logic [3:0]  tok_ep [NI], other_pid [NI];
  logic [10:0] sof_frame [NI];
  logic        err_pid [NI], err_crc [NI], err_len [NI], err_ep [NI];
  logic [15:0] err_count [NI];
  logic [2:0]  dbg_state [NI];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit mon_off = 1'b1;
  logic [W-1:0] exp_q [NI][$];
  logic [15:0]  exp_err [NI];
  logic [7:0]   pkt [8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    axi_stream_iface rx_if ();
    assign rx_if.tvalid = tvalid;
    assign rx_if.tdata  = tdata;
    assign rx_if.tlast  = tlast;
    assign tready_w[g]  = rx_if.tready;
    usb_token_decoder #(.NUM_EP(NE_P[g]), .CHECK_CRC(CC_P[g]), .ADDR_FILTER(AF_P[g])) u_dut (
      .clk(clk), .rst_n(rst_n), .rx(rx_if), .dev_addr(dev_addr),
      .tok_valid(tok_valid[g]), .tok_type(tok_type[g]), .tok_addr(tok_addr[g]),
      .tok_ep(tok_ep[g]), .sof_valid(sof_valid[g]), .sof_frame(sof_frame[g]),
      .other_valid(other_valid[g]), .other_pid(other_pid[g]),
      .err_pid(err_pid[g]), .err_crc(err_crc[g]), .err_len(err_len[g]),
      .err_ep(err_ep[g]), .err_count(err_count[g]), .dbg_state(dbg_state[g])
    );
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] expv);
    total++;
    assert (act === expv) else begin
      bad++;
      $error("FAIL %s: got %0h, need %0h", tag, act, expv);
    end
  endtask

  // Reference CRC5: USB token CRC over 11 bits sent LSB-first, returned
  // in the inverted form the packet carries.
  function automatic logic [4:0] ref_crc5(input logic [10:0] d);
    int r;
    r = 31;
    for (int i = 0; i < 11; i++) begin
      if (((r >> 4) & 1) != int'(d[i])) r = ((r << 1) & 31) ^ 5;
      else                               r = (r << 1) & 31;
    end
    return ~5'(r);
  endfunction

  task automatic push(input int k, input logic [3:0] kind, input logic [15:0] data,
                      input int at, input bit timed);
    exp_q[k].push_back({timed, 31'(at), 8'h00, kind, 4'h0, data});
    if (kind >= K_PID && exp_err[k] != 16'hffff) exp_err[k] = exp_err[k] + 16'd1;
  endtask

  // Packet-level outcome for instance k of pkt[0..n-1]; base is the clock
  // edge on which pkt[0] is accepted.
  task automatic predict(input int k, input int n, input int base, input bit timed);
    logic [7:0] pid;
    logic [6:0] addr;
    logic [3:0] ep;
    pid  = pkt[0];
    addr = pkt[1][6:0];
    ep   = {pkt[2][2:0], pkt[1][7]};
    if (pid[7:4] != ~pid[3:0])         push(k, K_PID, 16'h0, base, timed);
    else if (pid[1:0] != 2'b01)        push(k, K_OTH, {12'h0, pid[3:0]}, base, timed);
    else if (n == 1)                   push(k, K_LEN, 16'h0, base, timed);
    else if (n == 2)                   push(k, K_LEN, 16'h0, base + 1, timed);
    else if (n > 3)                    push(k, K_LEN, 16'h0, base + 2, timed);
    else if (CC_P[k] != 0 && pkt[2][7:3] != ref_crc5({ep, addr}))
                                       push(k, K_CRC, 16'h0, base + 3, timed);
    else if (pid[3:2] == 2'b01)        push(k, K_SOF, {5'h0, ep, addr}, base + 3, timed);
    else if (AF_P[k] != 0 && addr != dev_addr) begin
      // filtered: no pulse expected
    end
    else if (int'(ep) >= NE_P[k])      push(k, K_EP, 16'h0, base + 3, timed);
    else                               push(k, K_TOK, {3'h0, pid[3:2], ep, addr}, base + 3, timed);
  endtask

  task automatic beat(input logic [7:0] b, input logic last);
    tvalid = 1'b1;
    tdata  = b;
    tlast  = last;
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic idle(input int n);
    tvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input int n, input bit timed);
    for (int k = 0; k < NI; k++) predict(k, n, cyc + 1, timed);
    for (int i = 0; i < n; i++) beat(pkt[i], i == n - 1);
  endtask

  task automatic set3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    pkt[0] = a; pkt[1] = b; pkt[2] = c; pkt[3] = 8'h00;
  endtask

  task automatic drain(input string tag);
    idle(5);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("%s_i%0d_pending", tag, k), 64'(exp_q[k].size()), 64'd0);
      chk($sformatf("%s_i%0d_err_count", tag, k), 64'(err_count[k]), 64'(exp_err[k]));
    end
  endtask

  task automatic do_reset();
    mon_off = 1'b1;
    tvalid  = 1'b0;
    tlast   = 1'b0;
    rst_n   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < NI; k++) begin
      exp_q[k].delete();
      exp_err[k] = 16'h0;
      chk($sformatf("reset_i%0d_outputs", k),
          64'({tok_valid[k], sof_valid[k], other_valid[k], err_pid[k], err_crc[k],
               err_len[k], err_ep[k], tok_type[k], tok_addr[k], tok_ep[k],
               sof_frame[k], other_pid[k], err_count[k]}), 64'd0);
      chk($sformatf("reset_i%0d_tready", k), 64'(tready_w[k]), 64'd1);
    end
    mon_off = 1'b0;
  endtask

  // Scoreboard: every observed pulse must match the head of the instance's
  // expected queue (kind, data and, when timed, the exact cycle).
  always @(negedge clk) begin
    if (!mon_off) begin
      for (int k = 0; k < NI; k++) begin
        int np;
        logic [3:0] ok;
        logic [15:0] od;
        logic [W-1:0] f;
        np = int'(tok_valid[k]) + int'(sof_valid[k]) + int'(other_valid[k]) +
             int'(err_pid[k]) + int'(err_crc[k]) + int'(err_len[k]) + int'(err_ep[k]);
        total++;
        assert (np <= 1) else begin
          bad++;
          $error("FAIL i%0d_onehot: got %0d pulses, need at most 1", k, np);
        end
        ok = K_NONE;
        od = 16'h0;
        if (tok_valid[k])        begin ok = K_TOK; od = {3'h0, tok_type[k], tok_ep[k], tok_addr[k]}; end
        else if (sof_valid[k])   begin ok = K_SOF; od = {5'h0, sof_frame[k]}; end
        else if (other_valid[k]) begin ok = K_OTH; od = {12'h0, other_pid[k]}; end
        else if (err_pid[k])     ok = K_PID;
        else if (err_len[k])     ok = K_LEN;
        else if (err_crc[k])     ok = K_CRC;
        else if (err_ep[k])      ok = K_EP;
        if (exp_q[k].size() > 0) begin
          f = exp_q[k][0];
          if (f[63] && int'(f[62:32]) < cyc) begin
            void'(exp_q[k].pop_front());
            total++;
            bad++;
            $error("FAIL i%0d_missing: got nothing, need kind %0d at cycle %0d",
                   k, f[23:20], int'(f[62:32]));
          end
        end
        if (ok != K_NONE) begin
          total++;
          assert (exp_q[k].size() != 0) else begin
            bad++;
            $error("FAIL i%0d_unexpected: got kind %0d data %0h, need no pulse", k, ok, od);
          end
          if (exp_q[k].size() != 0) begin
            f = exp_q[k].pop_front();
            chk($sformatf("i%0d_kind", k), 64'(ok), 64'(f[23:20]));
            chk($sformatf("i%0d_data", k), 64'(od), 64'(f[15:0]));
            if (f[63]) chk($sformatf("i%0d_cycle", k), 64'(cyc), 64'(f[62:32]));
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ra;
    logic [3:0] re;
    logic [4:0] rc;
    int n;
    do_reset();

    // Directed reference packets
    dev_addr = 7'h15;
    set3(8'h2D, 8'h15, 8'hBF); send_pkt(3, 1'b1); idle(2);   // SETUP 0x15 ep 0xE
    set3(8'hA5, 8'h10, 8'hA7); send_pkt(3, 1'b1); idle(2);   // SOF 0x710
    set3(8'hA5, 8'h10, 8'hA6); send_pkt(3, 1'b1); idle(2);   // SOF with bad CRC
    set3(8'h69, 8'h3A, 8'hE5); send_pkt(3, 1'b1); idle(2);   // IN to other address
    dev_addr = 7'h70;
    set3(8'hE1, 8'h70, 8'h72); send_pkt(3, 1'b1); idle(2);   // OUT ep 4
    dev_addr = 7'h15;
    set3(8'h2D, 8'h15, 8'hBF); send_pkt(2, 1'b1); idle(2);   // short token
    pkt[3] = 8'h00;            send_pkt(4, 1'b1); idle(2);   // long token
    set3(8'h2C, 8'h11, 8'h22); send_pkt(3, 1'b1); idle(2);   // bad PID
    set3(8'hC3, 8'h01, 8'h02); send_pkt(3, 1'b1); idle(2);   // DATA0
    set3(8'h69, 8'h15, 8'h00); send_pkt(1, 1'b1); idle(2);   // one-byte token
    drain("directed");

    // Randomized packets, one idle cycle or more between packets
    for (int p = 0; p < 300; p++) begin
      if ($urandom_range(0, 9) == 0) pkt[0] = 8'($urandom_range(0, 255));
      else                           pkt[0] = PID_TAB[$urandom_range(0, 7)];
      ra = $urandom_range(0, 1) ? dev_addr : 7'($urandom_range(0, 127));
      re = 4'($urandom_range(0, 15));
      rc = ($urandom_range(0, 3) != 0) ? ref_crc5({re, ra}) : 5'($urandom_range(0, 31));
      pkt[1] = {re[0], ra};
      pkt[2] = {rc, re[3:1]};
      pkt[3] = 8'($urandom_range(0, 255));
      pkt[4] = 8'($urandom_range(0, 255));
      n = ($urandom_range(0, 9) < 7) ? 3 : $urandom_range(1, 5);
      send_pkt(n, 1'b1);
      idle($urandom_range(1, 2));
    end
    drain("random");

    // Back-to-back packets: only order and content are predicted
    set3(8'h2D, 8'h15, 8'hBF); send_pkt(3, 1'b0);
    set3(8'hC3, 8'h00, 8'h00); send_pkt(1, 1'b0);
    set3(8'h2C, 8'h00, 8'h00); send_pkt(1, 1'b0);
    set3(8'hA5, 8'h10, 8'hA7); send_pkt(3, 1'b0);
    set3(8'h2D, 8'h15, 8'hBF); send_pkt(3, 1'b0);
    set3(8'h69, 8'h15, 8'hBF); send_pkt(3, 1'b0);
    drain("b2b");

    // Reset in the middle of a token, then a clean token
    beat(8'h2D, 1'b0);
    beat(8'h15, 1'b0);
    do_reset();
    set3(8'h2D, 8'h15, 8'hBF); send_pkt(3, 1'b1);
    drain("midreset");

    // Error counter saturation
    mon_off = 1'b1;
    tvalid = 1'b1; tdata = 8'h00; tlast = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    idle(4);
    for (int k = 0; k < NI; k++) begin
      exp_q[k].delete();
      exp_err[k] = 16'hffff;
    end
    mon_off = 1'b0;
    drain("saturate");
    set3(8'h2C, 8'h00, 8'h00); send_pkt(1, 1'b1);
    drain("sat_hold");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
